acc_dump_vout_ctrl: RTL
=======================

ACC_DUMP_VOUT_CTRL -- requirements
Module: acc_dump_vout_ctrl

Interface
REQ-001 SHALL have parameter TCQ, default 0.1, register output delay.
REQ-002 SHALL have parameter ADDR_WIDTH, default 30, DDR address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, DDR address unit in bits.
REQ-004 SHALL have parameter MEM_DATA_BITS, default 256, DDR beat width.
REQ-005 SHALL have parameter BURST_LEN, default 128, maximum beats per burst (range 1..255).
REQ-006 SHALL use one clock and a synchronous, active-high reset: ddr_clk_i  in  1  sole clock; ddr_rst_i  in  1  synchronous active-high reset.
REQ-007 SHALL have port readback_start_i  in  1  single-cycle start pulse.
REQ-008 SHALL have port readback_base_addr_i  in  ADDR_WIDTH  first DDR address, sampled on start.
REQ-009 SHALL have port readback_beats_i  in  24  total beats to read, sampled on start.
REQ-010 SHALL have ports rd_ddr_req_o  out  1  read request; rd_ddr_len_o  out  8  burst beats; rd_ddr_addr_o  out  ADDR_WIDTH  burst start address.
REQ-011 SHALL have ports rd_ddr_data_vld_i  in  1  beat valid; rd_ddr_data_i  in  MEM_DATA_BITS  beat data; rd_ddr_finish_i  in  1  burst complete pulse.
REQ-012 SHALL have ports readback_vld_o  out  1; readback_data_o  out  MEM_DATA_BITS; readback_rdy_i  in  1; downstream stream.
REQ-013 SHALL have ports readback_busy_o  out  1  transfer active; readback_done_o  out  1  one-cycle completion pulse; readback_ovf_o  out  1  sticky overflow flag.

Function
REQ-014 SHALL contain a synchronous show-ahead buffer of depth 2*BURST_LEN, MEM_DATA_BITS wide.
REQ-015 SHALL implement FSM IDLE -> WAIT_SPACE -> REQ -> (WAIT_SPACE | DONE) -> IDLE.
REQ-016 IDLE: on readback_start_i, latch base address and beat count, go to WAIT_SPACE; if beat count is 0, go to DONE instead.
REQ-017 WAIT_SPACE: burst length = min(BURST_LEN, remaining beats); go to REQ when buffer free slots >= burst length.
REQ-018 REQ: rd_ddr_req_o held 1, with rd_ddr_len_o and rd_ddr_addr_o stable, until rd_ddr_finish_i is sampled; req SHALL be 0 the following cycle.
REQ-019 On finish: address += burst length * (MEM_DATA_BITS/DATA_WIDTH), modulo 2^ADDR_WIDTH; remaining -= burst length; go to DONE if remaining is 0, else WAIT_SPACE.
REQ-020 DONE: readback_done_o = 1 for exactly one cycle, then IDLE.
REQ-021 readback_busy_o SHALL be 1 in every state except IDLE.
REQ-022 Every rd_ddr_data_vld_i beat SHALL be written into the buffer the same cycle, in order.
REQ-023 A beat arriving while the buffer is full SHALL be dropped and SHALL set readback_ovf_o.
REQ-024 readback_vld_o = buffer not empty; pop on readback_vld_o & readback_rdy_i; readback_data_o SHALL hold while vld=1 and rdy=0.
REQ-025 Simultaneous push and pop on a full buffer SHALL succeed without overflow.
REQ-026 readback_start_i SHALL be ignored outside IDLE.
REQ-027 With an empty buffer, rd_ddr_req_o SHALL rise exactly 2 cycles after readback_start_i.

Reset
REQ-028 While ddr_rst_i = 1, FSM = IDLE, buffer flushed, and all outputs = 0, including address/length, data, and ovf.
REQ-029 Reset asserted mid-burst SHALL abort the transfer; beats arriving afterwards SHALL be discarded until the next start.

Configuration
REQ-030 Macro ACC_DUMP_VOUT_OVF_CHECK_EN: when defined, REQ-023 overflow detection is built and readback_ovf_o is sticky until reset.
REQ-031 When ACC_DUMP_VOUT_OVF_CHECK_EN is undefined, readback_ovf_o SHALL be constant 0 and full-buffer beats are dropped silently.

Verification
REQ-032 base=0x100, beats=300, rdy=1 -> bursts len 128/128/44 at addr 0x100/0x500/0x900, 300 beats out in order, one done pulse.
REQ-033 beats=0 -> no rd_ddr_req_o, done pulse 1 cycle after start, busy high 1 cycle.
REQ-034 beats=384, rdy=0 -> two bursts complete, third withheld; raise rdy -> third burst issued once 128 slots free; 384 beats delivered.
REQ-035 base=0x3FFFFC00, beats=256 -> second burst addr 0x00000000 (wrap).
REQ-036 Start pulse mid-transfer -> ignored; assert reset during burst 2 -> req and busy 0 next cycle, vld 0, no done pulse.
REQ-037 With macro defined, inject an extra beat into a full buffer -> readback_ovf_o = 1 and stays 1; without the macro -> stays 0.

Source files
------------

// File: rtl/acc_dump_vout_ctrl.sv
// DDR readback controller: splits a transfer into bursts of at most BURST_LEN beats and streams them
// out through a 2*BURST_LEN show-ahead buffer. Define ACC_DUMP_VOUT_OVF_CHECK_EN to build the sticky overflow flag.
module acc_dump_vout_ctrl #(
   parameter real TCQ           = 0.1,
   parameter int  ADDR_WIDTH    = 30,
   parameter int  DATA_WIDTH    = 32,
   parameter int  MEM_DATA_BITS = 256,
   parameter int  BURST_LEN     = 128
) (
   input  logic                     ddr_clk_i,
   input  logic                     ddr_rst_i,
   input  logic                     readback_start_i,
   input  logic [ADDR_WIDTH-1:0]    readback_base_addr_i,
   input  logic [23:0]              readback_beats_i,
   output logic                     rd_ddr_req_o,
   output logic [7:0]               rd_ddr_len_o,
   output logic [ADDR_WIDTH-1:0]    rd_ddr_addr_o,
   input  logic                     rd_ddr_data_vld_i,
   input  logic [MEM_DATA_BITS-1:0] rd_ddr_data_i,
   input  logic                     rd_ddr_finish_i,
   output logic                     readback_vld_o,
   output logic [MEM_DATA_BITS-1:0] readback_data_o,
   input  logic                     readback_rdy_i,
   output logic                     readback_busy_o,
   output logic                     readback_done_o,
   output logic                     readback_ovf_o
);
   localparam int DEPTH          = 2 * BURST_LEN;
   localparam int PTR_W          = $clog2(DEPTH);
   localparam int CNT_W          = $clog2(DEPTH + 1);
   localparam int WORDS_PER_BEAT = MEM_DATA_BITS / DATA_WIDTH;

   typedef enum logic [1:0] {IDLE, WAIT_SPACE, REQ, DONE} state_t;
   state_t state;

   logic [23:0]              remaining;
   logic                     accept;
   logic [MEM_DATA_BITS-1:0] mem [DEPTH];
   logic [PTR_W-1:0]         wr_ptr;
   logic [PTR_W-1:0]         rd_ptr;
   logic [CNT_W-1:0]         count;
   logic                     full;
   logic                     empty;
   logic                     push;
   logic                     pop;
   logic [CNT_W-1:0]         free_slots;
   logic [7:0]               burst_len;
   logic [ADDR_WIDTH-1:0]    addr_step;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // A full buffer still accepts a beat when the head is popped in the same cycle.
   always_comb begin
      full       = (count == CNT_W'(DEPTH));
      empty      = (count == '0);
      pop        = !empty && readback_rdy_i;
      push       = rd_ddr_data_vld_i && accept && (!full || pop);
      free_slots = CNT_W'(DEPTH) - count;
      burst_len  = (remaining < 24'(BURST_LEN)) ? remaining[7:0] : 8'(BURST_LEN);
      addr_step  = ADDR_WIDTH'(32'(rd_ddr_len_o) * 32'(WORDS_PER_BEAT));
   end

   always_ff @(posedge ddr_clk_i) begin
      if (push) mem[wr_ptr] <= rd_ddr_data_i;
   end

   always_ff @(posedge ddr_clk_i) begin
      if (ddr_rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= next_ptr(wr_ptr);
         if (pop)  rd_ptr <= next_ptr(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   assign readback_vld_o  = !empty;
   assign readback_data_o = empty ? '0 : mem[rd_ptr];

`ifdef ACC_DUMP_VOUT_OVF_CHECK_EN
   logic ovf_q;
   always_ff @(posedge ddr_clk_i) begin
      if (ddr_rst_i) ovf_q <= 1'b0;
      else if (rd_ddr_data_vld_i && accept && full && !pop) ovf_q <= 1'b1;
   end
   assign readback_ovf_o = ovf_q;
`else
   assign readback_ovf_o = 1'b0;
`endif

   // accept stays low after reset so beats of an aborted burst never reach the buffer.
   always_ff @(posedge ddr_clk_i) begin
      if (ddr_rst_i) begin
         state           <= IDLE;
         remaining       <= '0;
         accept          <= 1'b0;
         rd_ddr_req_o    <= 1'b0;
         rd_ddr_len_o    <= '0;
         rd_ddr_addr_o   <= '0;
         readback_busy_o <= 1'b0;
         readback_done_o <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               readback_done_o <= 1'b0;
               if (readback_start_i) begin
                  rd_ddr_addr_o   <= readback_base_addr_i;
                  remaining       <= readback_beats_i;
                  accept          <= 1'b1;
                  readback_busy_o <= 1'b1;
                  if (readback_beats_i == '0) begin
                     state           <= DONE;
                     readback_done_o <= 1'b1;
                  end else begin
                     state <= WAIT_SPACE;
                  end
               end
            end
            WAIT_SPACE: begin
               if (32'(free_slots) >= 32'(burst_len)) begin
                  rd_ddr_req_o <= 1'b1;
                  rd_ddr_len_o <= burst_len;
                  state        <= REQ;
               end
            end
            REQ: begin
               if (rd_ddr_finish_i) begin
                  rd_ddr_req_o  <= 1'b0;
                  rd_ddr_addr_o <= rd_ddr_addr_o + addr_step;
                  remaining     <= remaining - 24'(rd_ddr_len_o);
                  if (remaining == 24'(rd_ddr_len_o)) begin
                     state           <= DONE;
                     readback_done_o <= 1'b1;
                  end else begin
                     state <= WAIT_SPACE;
                  end
               end
            end
            DONE: begin
               readback_done_o <= 1'b0;
               readback_busy_o <= 1'b0;
               state           <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
